// File: rtl/sa_chunked_addsub.sv
// sa_chunked_addsub: chunk-serial adder/subtractor.
// Operand slices arrive LS chunk first. The carry between slices is kept in a
// 1-bit register, and the result builds up in a right-shifting register.
// Subtraction is done as A + ~B + 1: the carry register is preloaded with 1.
module sa_chunked_addsub #(
    parameter int CHUNK_W    = 12,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          startChunks,
    input  logic                          subMode,
    input  logic                          chunkValid,
    input  logic [CHUNK_W-1:0]            inBusA,
    input  logic [CHUNK_W-1:0]            inBusB,
    output logic                          busy,
    output logic                          resultReady,
    output logic [CHUNK_W*NUM_CHUNKS-1:0] outBus,
    output logic                          carryOut,
    output logic                          overflow
);

    localparam int RES_W = CHUNK_W * NUM_CHUNKS;
    localparam int CNT_W = (NUM_CHUNKS > 2) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic               sub_mode;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [CHUNK_W-1:0] b_eff;
    logic [CHUNK_W:0]   sum;
    logic               msb_carry_in;
    logic               last_chunk;

    // Slice adder. B is inverted when subtracting.
    // The carry into the slice MSB is recovered from the sum bit, for overflow.
    always_comb begin
        b_eff        = inBusB ^ {CHUNK_W{sub_mode}};
        sum          = {1'b0, inBusA} + {1'b0, b_eff} + {{CHUNK_W{1'b0}}, carry};
        msb_carry_in = inBusA[CHUNK_W-1] ^ b_eff[CHUNK_W-1] ^ sum[CHUNK_W-1];
        last_chunk   = (cnt == CNT_W'(NUM_CHUNKS - 1));
    end

    // Control FSM and datapath registers. A stall simply holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sub_mode <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            outBus   <= '0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (startChunks) begin
                        state    <= ST_RUN;
                        sub_mode <= subMode;
                        carry    <= subMode;
                        cnt      <= '0;
                        outBus   <= '0;
                        carryOut <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (chunkValid) begin
                        outBus <= {sum[CHUNK_W-1:0], outBus[RES_W-1:CHUNK_W]};
                        carry  <= sum[CHUNK_W];
                        if (last_chunk) begin
                            state    <= ST_DONE;
                            carryOut <= sum[CHUNK_W];
                            overflow <= msb_carry_in ^ sum[CHUNK_W];
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status outputs decode directly from the state.
    always_comb begin
        busy        = (state == ST_RUN);
        resultReady = (state == ST_DONE);
    end

endmodule

// File: tb/tb_sa_chunked_addsub.sv
// tb_sa_chunked_addsub: scoreboard bench for the chunk-serial adder/subtractor.
// dut0 uses 12-bit x 4 slices. dut1 uses 8-bit x 3 slices and runs the random op series.
// Expected results come from whole-operand arithmetic.
module tb_sa_chunked_addsub;

    localparam int CW0 = 12;
    localparam int NC0 = 4;
    localparam int RW0 = 48;
    localparam int CW1 = 8;
    localparam int NC1 = 3;
    localparam int RW1 = 24;

    typedef struct packed {
        logic [63:0] res;
        logic        c;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start0, sub0, cv0, busy0, rr0, co0, ov0;
    logic [CW0-1:0] a0, b0;
    logic [RW0-1:0] out0;
    logic start1, sub1, cv1, busy1, rr1, co1, ov1;
    logic [CW1-1:0] a1, b1;
    logic [RW1-1:0] out1;

    int n_checks = 0;
    int n_fail   = 0;
    longint cyc  = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sa_chunked_addsub #(.CHUNK_W(CW0), .NUM_CHUNKS(NC0)) dut0 (
        .clk(clk), .rst(rst), .startChunks(start0), .subMode(sub0),
        .chunkValid(cv0), .inBusA(a0), .inBusB(b0), .busy(busy0),
        .resultReady(rr0), .outBus(out0), .carryOut(co0), .overflow(ov0)
    );

    sa_chunked_addsub #(.CHUNK_W(CW1), .NUM_CHUNKS(NC1)) dut1 (
        .clk(clk), .rst(rst), .startChunks(start1), .subMode(sub1),
        .chunkValid(cv1), .inBusA(a1), .inBusB(b1), .busy(busy1),
        .resultReady(rr1), .outBus(out1), .carryOut(co1), .overflow(ov1)
    );

    // Reference: full-width arithmetic with signed-overflow rules
    function automatic exp_t model(input longint unsigned a, input longint unsigned b,
                                   input logic sub, input int w);
        longint unsigned mask;
        exp_t e;
        logic sa, sb, sr;
        mask = (64'd1 << w) - 64'd1;
        if (sub) begin
            e.res = (a - b) & mask;
            e.c   = (a >= b);
        end else begin
            e.res = (a + b) & mask;
            e.c   = ((a + b) >> w) != 64'd0;
        end
        sa = a[w-1];
        sb = b[w-1];
        sr = e.res[w-1];
        e.ov = sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
        return e;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete dut0 operation, with a random stall count before each slice
    task automatic run_op0(input longint unsigned a, input longint unsigned b, input logic sub,
                           input int stall_min, input int stall_max, input logic hold_start,
                           output int lat);
        longint t0;
        int st;
        q0.push_back(model(a, b, sub, RW0));
        @(posedge clk); #1;
        start0 = 1'b1; sub0 = sub; cv0 = 1'b0; t0 = cyc;
        @(posedge clk); #1;
        start0 = hold_start; sub0 = 1'($urandom);
        for (int i = 0; i < NC0; i++) begin
            st = $urandom_range(stall_max, stall_min);
            repeat (st) begin
                cv0 = 1'b0; a0 = CW0'($urandom); b0 = CW0'($urandom);
                @(posedge clk); #1;
            end
            cv0 = 1'b1;
            a0 = CW0'(a >> (i * CW0));
            b0 = CW0'(b >> (i * CW0));
            if (i == NC0 - 1) begin
                start0 = 1'b0;
                check("rr0_before_last", 64'(rr0), 64'd0);
            end
            @(posedge clk); #1;
        end
        cv0 = 1'b0; a0 = CW0'($urandom); b0 = CW0'($urandom);
        check("rr0_after_last", 64'(rr0), 64'd1);
        lat = int'(cyc - t0);
    endtask

    // One complete dut1 operation with random stalls
    task automatic run_op1(input longint unsigned a, input longint unsigned b, input logic sub);
        int st;
        q1.push_back(model(a, b, sub, RW1));
        @(posedge clk); #1;
        start1 = 1'b1; sub1 = sub; cv1 = 1'($urandom);
        @(posedge clk); #1;
        start1 = 1'($urandom); sub1 = 1'($urandom);
        for (int i = 0; i < NC1; i++) begin
            st = $urandom_range(2, 0);
            repeat (st) begin
                cv1 = 1'b0; a1 = CW1'($urandom); b1 = CW1'($urandom);
                @(posedge clk); #1;
            end
            cv1 = 1'b1;
            a1 = CW1'(a >> (i * CW1));
            b1 = CW1'(b >> (i * CW1));
            if (i == NC1 - 1) start1 = 1'b0;
            @(posedge clk); #1;
        end
        cv1 = 1'b0;
        check("rr1_after_last", 64'(rr1), 64'd1);
    endtask

    function automatic longint unsigned pick24();
        case ($urandom_range(7, 0))
            0:       return 64'h0;
            1:       return 64'hFFFFFF;
            2:       return 64'h800000;
            3:       return 64'h7FFFFF;
            default: return longint'($urandom) & 64'hFFFFFF;
        endcase
    endfunction

    // dut0 scoreboard monitor: compare on every new resultReady
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rr0 && !prev0) begin
                if (q0.size() == 0) begin
                    check("sb0_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q0.pop_front();
                    check("sb0_outBus", 64'(out0), e.res);
                    check("sb0_carryOut", 64'(co0), 64'(e.c));
                    check("sb0_overflow", 64'(ov0), 64'(e.ov));
                end
            end
            prev0 = rr0;
        end
    end

    // dut1 scoreboard monitor: compare on every new resultReady
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rr1 && !prev1) begin
                if (q1.size() == 0) begin
                    check("sb1_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q1.pop_front();
                    check("sb1_outBus", 64'(out1), e.res);
                    check("sb1_carryOut", 64'(co1), 64'(e.c));
                    check("sb1_overflow", 64'(ov1), 64'(e.ov));
                end
            end
            prev1 = rr1;
        end
    end

    // Watchdog so a stuck run still ends with a report
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        int lat;
        rst = 1'b1;
        start0 = 0; sub0 = 0; cv0 = 0; a0 = '0; b0 = '0;
        start1 = 0; sub1 = 0; cv1 = 0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outBus0", 64'(out0), 64'd0);
        check("reset_busy0", 64'(busy0), 64'd0);
        check("reset_rr0", 64'(rr0), 64'd0);
        check("reset_carry0", 64'(co0), 64'd0);
        check("reset_ovf0", 64'(ov0), 64'd0);
        check("reset_outBus1", 64'(out1), 64'd0);
        check("reset_busy1", 64'(busy1), 64'd0);
        check("reset_rr1", 64'(rr1), 64'd0);
        rst = 1'b0;

        $display("[TB] directed add/sub cases");
        run_op0(64'hFFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 0, 1'b0, lat);
        check("t1_latency", 64'(lat), 64'd5);
        run_op0(64'h5, 64'h7, 1'b1, 0, 0, 1'b0, lat);
        check("t2_latency", 64'(lat), 64'd5);
        run_op0(64'h7FFF_FFFF_FFFF, 64'h1, 1'b0, 0, 0, 1'b0, lat);
        run_op0(64'h8000_0000_0000, 64'h1, 1'b1, 0, 0, 1'b0, lat);

        $display("[TB] stalled op with start held high in RUN");
        run_op0(64'hFFFF_FFFF_FFFF, 64'h1, 1'b0, 3, 3, 1'b1, lat);
        check("t4_latency", 64'(lat), 64'd17);

        $display("[TB] reset abort after two slices");
        @(posedge clk); #1;
        start0 = 1'b1; sub0 = 1'b0;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cv0 = 1'b1; a0 = 12'hABC; b0 = 12'h123;
            @(posedge clk); #1;
        end
        check("abort_busy_before", 64'(busy0), 64'd1);
        cv0 = 1'b0; rst = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start0 = 1'b0;
        check("abort_outBus", 64'(out0), 64'd0);
        check("abort_busy", 64'(busy0), 64'd0);
        check("abort_rr", 64'(rr0), 64'd0);
        check("abort_carry", 64'(co0), 64'd0);
        check("abort_ovf", 64'(ov0), 64'd0);
        run_op0(64'h123_456_789_ABC, 64'h111_111_111_111, 1'b0, 0, 0, 1'b0, lat);
        check("t5_latency", 64'(lat), 64'd5);

        $display("[TB] random ops on the 48-bit instance");
        repeat (20) begin
            run_op0({longint'($urandom), longint'($urandom)} & 64'hFFFF_FFFF_FFFF,
                    {longint'($urandom), longint'($urandom)} & 64'hFFFF_FFFF_FFFF,
                    1'($urandom), 0, 2, 1'($urandom), lat);
        end

        $display("[TB] 500 random ops on the 24-bit instance");
        repeat (500) run_op1(pick24(), pick24(), 1'($urandom));

        repeat (3) @(posedge clk);
        #1;
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
